// File: rtl/shiftreg_pkg.sv
// Shared definitions for the universal shift register and its loader.
// The register, the loader and the bench all use these sel encodings.
package shiftreg_pkg;

  localparam logic [1:0] SEL_CLEAR = 2'b00;
  localparam logic [1:0] SEL_LEFT  = 2'b01;
  localparam logic [1:0] SEL_RIGHT = 2'b10;
  localparam logic [1:0] SEL_HOLD  = 2'b11;

  typedef enum logic [1:0] {CLEAR, IDLE, LOAD, DONE} loader_state_t;

endpackage

// File: rtl/shiftreg_loader_if.sv
// Word-in handshake plus register drive bundle between upstream, loader and register.
interface shiftreg_loader_if #(
  parameter int WIDTH = 4
);
  logic [WIDTH-1:0] in_data;
  logic             in_dir;
  logic             in_valid;
  logic             in_ready;
  logic             clear_req;
  logic [1:0]       sel_o;
  logic             ser_o;
  logic             busy;
  logic             done;

  modport master (
    output in_data, in_dir, in_valid, clear_req,
    input  in_ready, sel_o, ser_o, busy, done
  );

  modport slave (
    input  in_data, in_dir, in_valid, clear_req,
    output in_ready, sel_o, ser_o, busy, done
  );
endinterface

// File: rtl/shiftreg_loader.sv
// Sequencer that serially loads a parallel word into the universal shift register.
// Moore FSM: outputs decode only from state, bit counter and latched word.
module shiftreg_loader
  import shiftreg_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  shiftreg_loader_if.slave bus
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  loader_state_t    state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] word_q, word_d;
  logic             dir_q, dir_d;
  logic [CNT_W-1:0] bit_idx;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= CLEAR;
      cnt_q   <= '0;
      word_q  <= '0;
      dir_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      word_q  <= word_d;
      dir_q   <= dir_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    word_d  = word_q;
    dir_d   = dir_q;
    unique case (state_q)
      CLEAR: state_d = IDLE;
      IDLE: begin
        // A clear request wins; the pending word waits for the next IDLE cycle.
        if (bus.clear_req) begin
          state_d = CLEAR;
        end else if (bus.in_valid) begin
          state_d = LOAD;
          cnt_d   = '0;
          word_d  = bus.in_data;
          dir_d   = bus.in_dir;
        end
      end
      LOAD: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_LAST) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = CLEAR;
    endcase
  end

  // Left loads go MSB first (enter at LSB), right loads LSB first (enter at MSB).
  assign bit_idx = dir_q ? cnt_q : (CNT_LAST - cnt_q);

  always_comb begin
    bus.sel_o    = SEL_HOLD;
    bus.ser_o    = 1'b0;
    bus.in_ready = 1'b0;
    bus.busy     = 1'b1;
    bus.done     = 1'b0;
    unique case (state_q)
      CLEAR: bus.sel_o = SEL_CLEAR;
      IDLE: begin
        bus.in_ready = 1'b1;
        bus.busy     = 1'b0;
      end
      LOAD: begin
        bus.sel_o = dir_q ? SEL_RIGHT : SEL_LEFT;
        bus.ser_o = word_q[bit_idx];
      end
      DONE:    bus.done = 1'b1;
      default: bus.sel_o = SEL_CLEAR;
    endcase
  end

endmodule

// File: tb/tb_shiftreg_loader.sv
// Directed bench: loader driving a 4-bit universal shift register model; checks q and handshake.
module tb_shiftreg_loader;
  import shiftreg_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] q;
  int         n_vec = 0;
  int         n_err = 0;
  int         cyc = 0;
  int         acc_last = 0;
  int         acc_prev = 0;

  shiftreg_loader_if #(.WIDTH(4)) bus ();

  shiftreg_loader #(.WIDTH(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Downstream universal shift register
  always @(posedge clk) begin
    case (bus.sel_o)
      SEL_CLEAR: q <= 4'b0000;
      SEL_LEFT:  q <= {q[2:0], bus.ser_o};
      SEL_RIGHT: q <= {bus.ser_o, q[3:1]};
      default:   q <= q;
    endcase
  end

  always @(posedge clk) begin
    cyc = cyc + 1;
    if (!rst && bus.in_valid && bus.in_ready) begin
      acc_prev = acc_last;
      acc_last = cyc;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Accept, four LOAD cycles, DONE, IDLE. seq[3] is the first serial bit.
  task automatic run_load(input logic [3:0] w, input logic d, input logic [3:0] seq, input string nm);
    bus.in_data = w; bus.in_dir = d; bus.in_valid = 1'b1;
    step();
    bus.in_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      n_vec++; if (bus.sel_o !== (d ? SEL_RIGHT : SEL_LEFT)) begin n_err++; $display("FAIL %s sel[%0d] got %b exp %b", nm, i, bus.sel_o, d ? SEL_RIGHT : SEL_LEFT); end
      n_vec++; if (bus.ser_o !== seq[3-i]) begin n_err++; $display("FAIL %s ser[%0d] got %b exp %b", nm, i, bus.ser_o, seq[3-i]); end
      n_vec++; if ({bus.busy, bus.in_ready, bus.done} !== 3'b100) begin n_err++; $display("FAIL %s load flags[%0d] got %b exp 100", nm, i, {bus.busy, bus.in_ready, bus.done}); end
      step();
    end
    n_vec++; if ({bus.done, bus.busy, bus.in_ready, bus.sel_o} !== 5'b11011) begin n_err++; $display("FAIL %s done-state got %b exp 11011", nm, {bus.done, bus.busy, bus.in_ready, bus.sel_o}); end
    n_vec++; if (q !== w) begin n_err++; $display("FAIL %s q@done got %b exp %b", nm, q, w); end
    step();
    n_vec++; if ({bus.done, bus.busy, bus.in_ready, bus.sel_o} !== 5'b00111) begin n_err++; $display("FAIL %s idle got %b exp 00111", nm, {bus.done, bus.busy, bus.in_ready, bus.sel_o}); end
    n_vec++; if (q !== w) begin n_err++; $display("FAIL %s q@idle got %b exp %b", nm, q, w); end
  endtask

  task automatic test_reset();
    bus.in_data = '0; bus.in_dir = 1'b0; bus.in_valid = 1'b0; bus.clear_req = 1'b0;
    #2;
    n_vec++; if ({bus.sel_o, bus.ser_o, bus.in_ready, bus.busy, bus.done} !== 6'b000010) begin n_err++; $display("FAIL reset outs got %b exp 000010", {bus.sel_o, bus.ser_o, bus.in_ready, bus.busy, bus.done}); end
    step();
    rst = 1'b0;
    n_vec++; if (bus.sel_o !== SEL_CLEAR) begin n_err++; $display("FAIL post-release sel got %b exp 00", bus.sel_o); end
    step();
    n_vec++; if ({bus.sel_o, bus.in_ready, bus.busy} !== 4'b1110) begin n_err++; $display("FAIL first idle got %b exp 1110", {bus.sel_o, bus.in_ready, bus.busy}); end
    n_vec++; if (q !== 4'b0000) begin n_err++; $display("FAIL reset q got %b exp 0000", q); end
    step();
    n_vec++; if (bus.sel_o !== SEL_HOLD || q !== 4'b0000) begin n_err++; $display("FAIL idle hold got sel %b q %b exp 11 0000", bus.sel_o, q); end
  endtask

  task automatic test_load_left();
    run_load(4'b1011, 1'b0, 4'b1011, "left1011");
  endtask

  task automatic test_load_right();
    run_load(4'b0110, 1'b1, 4'b0110, "right0110");
  endtask

  task automatic test_clear_priority();
    bus.clear_req = 1'b1; bus.in_valid = 1'b1; bus.in_data = 4'b1111; bus.in_dir = 1'b0;
    step();
    bus.clear_req = 1'b0;
    n_vec++; if ({bus.sel_o, bus.in_ready, bus.busy} !== 4'b0001) begin n_err++; $display("FAIL clear state got %b exp 0001", {bus.sel_o, bus.in_ready, bus.busy}); end
    step();
    n_vec++; if (q !== 4'b0000 || bus.in_ready !== 1'b1) begin n_err++; $display("FAIL after clear got q %b rdy %b exp 0000 1", q, bus.in_ready); end
    run_load(4'b1111, 1'b0, 4'b1111, "clr-then-1111");
  endtask

  task automatic test_back_to_back();
    bus.in_data = 4'b1000; bus.in_dir = 1'b0; bus.in_valid = 1'b1;
    step();
    for (int i = 0; i < 4; i++) begin
      bus.in_data = (i[0]) ? 4'b1111 : 4'b0001;
      n_vec++; if (bus.ser_o !== ((i == 0) ? 1'b1 : 1'b0)) begin n_err++; $display("FAIL b2b first ser[%0d] got %b exp %b", i, bus.ser_o, (i == 0)); end
      step();
    end
    bus.in_data = 4'b0001;
    n_vec++; if (bus.done !== 1'b1 || q !== 4'b1000) begin n_err++; $display("FAIL b2b first done got done %b q %b exp 1 1000", bus.done, q); end
    step();
    run_load(4'b0001, 1'b0, 4'b0001, "b2b-0001");
    n_vec++; if (acc_last - acc_prev !== 6) begin n_err++; $display("FAIL b2b spacing got %0d exp 6", acc_last - acc_prev); end
  endtask

  task automatic test_reset_mid_load();
    bus.in_data = 4'b1100; bus.in_dir = 1'b1; bus.in_valid = 1'b1;
    step();
    bus.in_valid = 1'b0;
    step();
    step();
    #2 rst = 1'b1;
    #1;
    n_vec++; if ({bus.sel_o, bus.busy, bus.done, bus.in_ready} !== 5'b00100) begin n_err++; $display("FAIL async abort got %b exp 00100", {bus.sel_o, bus.busy, bus.done, bus.in_ready}); end
    step();
    n_vec++; if (bus.done !== 1'b0 || q !== 4'b0000) begin n_err++; $display("FAIL abort no-done got done %b q %b exp 0 0000", bus.done, q); end
    rst = 1'b0;
    step();
    n_vec++; if (bus.in_ready !== 1'b1 || bus.sel_o !== SEL_HOLD) begin n_err++; $display("FAIL idle after abort got rdy %b sel %b exp 1 11", bus.in_ready, bus.sel_o); end
    run_load(4'b0101, 1'b0, 4'b0101, "post-abort0101");
  endtask

  initial begin
    test_reset();
    test_load_left();
    test_load_right();
    test_clear_priority();
    test_back_to_back();
    test_reset_mid_load();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/shiftreg_loader.md
# shiftreg_loader

Upstream sequencer for the 4-bit universal shift register. Accepts a parallel word plus a direction over a valid/ready handshake, then drives the register's `sel` and serial `in` inputs for WIDTH cycles so the register ends up holding the word. It also issues register clears on request and after reset, and pulses `done` when the register contents are valid.

## Interface
- `WIDTH`, default 4: bits per word. Must equal the downstream register width.
- `clk`  in  1  rising-edge clock, shared with the shift register.
- `rst`  in  1  asynchronous, active-high reset.
- `in_data`  in  WIDTH  word to load.
- `in_dir`  in  1  0 = load by shift-left, 1 = load by shift-right.
- `in_valid`  in  1  `in_data`/`in_dir` valid.
- `in_ready`  out  1  loader can accept a word this cycle.
- `clear_req`  in  1  request a one-cycle register clear.
- `sel_o`  out  2  to register `sel`: 00 clear, 01 left, 10 right, 11 hold.
- `ser_o`  out  1  to register serial `in`.
- `busy`  out  1  high in any state other than IDLE.
- `done`  out  1  one-cycle pulse; register holds the loaded word.

## Operation
- Moore FSM with states CLEAR, IDLE, LOAD, DONE. Outputs decode from the state register, the bit counter and the latched word.
- CLEAR: `sel_o`=00, `ser_o`=0, `in_ready`=0, `busy`=1. Next state is always IDLE.
- IDLE: `sel_o`=11, `ser_o`=0, `in_ready`=1, `busy`=0.
  - `clear_req` → CLEAR. `clear_req` has priority over `in_valid`; the word is not accepted that cycle.
  - Otherwise `in_valid` → latch `in_data` and `in_dir`, set counter to 0, go to LOAD.
- LOAD: `in_ready`=0, `busy`=1.
  - `sel_o` is 01 if dir=0, 10 if dir=1.
  - `ser_o` is `word[WIDTH-1-cnt]` for left (MSB first; it enters at the LSB and migrates up).
  - `ser_o` is `word[cnt]` for right (LSB first; it enters at the MSB and migrates down).
  - Counter increments each cycle. At cnt=WIDTH-1 the next state is DONE.
- DONE: `sel_o`=11, `done`=1, `busy`=1, `in_ready`=0. Next state is IDLE.
- `clear_req` outside IDLE is ignored; it is not queued.
- `in_valid` outside IDLE is ignored; the upstream holds it until `in_ready`.
- Counter width is $clog2(WIDTH). No wrap is possible because the exit is at WIDTH-1.

## Timing
- Reset (asynchronous, immediate): state=CLEAR, cnt=0, word=0.
  - Outputs during and immediately after reset: `sel_o`=00, `ser_o`=0, `in_ready`=0, `busy`=1, `done`=0.
  - The first edge after release → IDLE, so the register is cleared for exactly one edge.
- Reset mid-LOAD aborts the load: `sel_o` goes to 00 immediately, with no `done` pulse.
- Accept at edge E0, where `in_valid`&`in_ready` is sampled.
  - The register shifts at edges E1..E_WIDTH.
  - DONE occupies the cycle after E_WIDTH, and the register `q` equals the word during that cycle.
  - IDLE resumes after E_WIDTH+1.
- Throughput is one word per WIDTH+2 cycles. Back-to-back `in_valid` is accepted on the first IDLE cycle after DONE.
- Register contents persist through DONE and IDLE because `sel_o`=11 holds them.

## Structure
- Shared package `shiftreg_pkg`:
  - `SEL_CLEAR`=2'b00, `SEL_LEFT`=2'b01, `SEL_RIGHT`=2'b10, `SEL_HOLD`=2'b11, also used by the register and its bench.
  - `loader_state_t` enum: CLEAR, IDLE, LOAD, DONE.
- No sub-module; the counter and word latch are inline.
- The bench instantiates `shiftreg_loader` driving the existing universal shift register and checks `q`.

## Test plan
- Reset released, no traffic → `sel_o`=00 for one cycle, then 11. `in_ready`=1 from cycle 2. Register `q`=0000.
- `in_data`=4'b1011, `in_dir`=0 → `ser_o` sequence 1,0,1,1 with `sel_o`=01 for 4 cycles. `done` on cycle 6 after accept. `q`=1011.
- `in_data`=4'b0110, `in_dir`=1 → `ser_o` sequence 0,1,1,0 with `sel_o`=10. `done` pulse. `q`=0110.
- `clear_req` and `in_valid` (word 4'b1111) in the same IDLE cycle → one cycle of `sel_o`=00, `q`=0000. The word is accepted on the next IDLE cycle and `q`=1111 at `done`.
- `in_valid` held high across a load with a changing `in_data` → new data is ignored until `in_ready`. Back-to-back words 4'b1000 then 4'b0001 are spaced exactly 6 cycles apart.
- `rst` asserted after 2 LOAD cycles → `sel_o`=00 asynchronously with no `done`. After release the loader returns to IDLE and the next load of 4'b0101 completes correctly.
